// File: rtl/regfile_multiport.sv
// Multi-port integer register file with byte-masked write, write-to-read bypass,
// optional hardwired zero register and a busy scoreboard with reserve handshake.
module regfile_multiport #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [DATA_W/8-1:0]       be,
  input  logic [ADDR_W-1:0]         rd_addr,
  input  logic [DATA_W-1:0]         data_in,
  input  logic [NREAD*ADDR_W-1:0]   rs_addr,
  output logic [NREAD*DATA_W-1:0]   op,
  output logic [NREAD-1:0]          busy,
  input  logic                      rsv_valid,
  input  logic [ADDR_W-1:0]         rsv_addr,
  output logic                      rsv_ready,
  output logic [ADDR_W:0]           busy_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned NBYTE = DATA_W / 8;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam bit          ZR    = (ZERO_REG != 0);
  localparam bit          BP    = (BYPASS != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  sb;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] wr_data;
  logic              wr_act;
  logic              rsv_act;
  logic              inc;
  logic              dec;

  // Byte-merged value the write port will commit this cycle
  always_comb begin
    wr_data = regs[rd_addr];
    for (int k = 0; k < NBYTE; k++) begin
      if (be[k]) wr_data[8*k +: 8] = data_in[8*k +: 8];
    end
  end

  assign wr_act    = !rst && en && !(ZR && rd_addr == '0);
  assign rsv_ready = !rst && (!sb[rsv_addr] || (en && rd_addr == rsv_addr) ||
                              (ZR && rsv_addr == '0));
  assign rsv_act   = rsv_valid && rsv_ready && !(ZR && rsv_addr == '0);

  // Count follows actual bit transitions; a same-address set overrides the clear
  assign inc = rsv_act && !sb[rsv_addr];
  assign dec = wr_act && sb[rd_addr] && !(rsv_act && rsv_addr == rd_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      sb    <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_act) begin
        regs[rd_addr] <= wr_data;
        sb[rd_addr]   <= 1'b0;
      end
      if (rsv_act) sb[rsv_addr] <= 1'b1;
      cnt_q <= cnt_q + CNT_W'(inc) - CNT_W'(dec);
    end
  end

  assign busy_cnt = rst ? '0 : cnt_q;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] rs;
    logic              zero;
    logic              hit;

    assign rs   = rs_addr[i*ADDR_W +: ADDR_W];
    assign zero = ZR && rs == '0;
    assign hit  = BP && en && rd_addr == rs;

    assign op[i*DATA_W +: DATA_W] = (rst || zero) ? '0 : (hit ? wr_data : regs[rs]);
    assign busy[i] = !rst && !zero && sb[rs] && !hit;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: hand-checked vector table, then random traffic
// checked against a behavioural model through an expected-value queue.
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  be;
  logic [4:0]  rd_addr;
  logic [31:0] data_in;
  logic [9:0]  rs_addr;
  logic [63:0] op;
  logic [1:0]  busy;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic        rsv_ready;
  logic [5:0]  busy_cnt;

  always #5 clk = ~clk;

  regfile_multiport #(
    .DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .be(be), .rd_addr(rd_addr),
    .data_in(data_in), .rs_addr(rs_addr), .op(op), .busy(busy),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .busy_cnt(busy_cnt)
  );

  typedef struct packed {
    logic        rst;
    logic        en;
    logic [3:0]  be;
    logic [4:0]  rd;
    logic [31:0] din;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic        rv;
    logic [4:0]  ra;
    logic [31:0] op0;
    logic [31:0] op1;
    logic [1:0]  bsy;
    logic        rdy;
    logic [5:0]  cnt;
  } vec_t;

  vec_t        tbl[$];
  vec_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mregs [32];
  logic [31:0] msb;

  function automatic vec_t mk(logic r, logic e, logic [3:0] b, logic [4:0] rd,
                              logic [31:0] d, logic [4:0] s0, logic [4:0] s1,
                              logic v, logic [4:0] a, logic [31:0] o0,
                              logic [31:0] o1, logic [1:0] bs, logic rdy,
                              logic [5:0] c);
    vec_t t;
    t.rst = r; t.en = e; t.be = b; t.rd = rd; t.din = d; t.rs0 = s0; t.rs1 = s1;
    t.rv = v; t.ra = a; t.op0 = o0; t.op1 = o1; t.bsy = bs; t.rdy = rdy; t.cnt = c;
    return t;
  endfunction

  function automatic logic [31:0] mmerge(logic [31:0] old, logic [31:0] d, logic [3:0] b);
    logic [31:0] r = old;
    for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mread(vec_t v, logic [4:0] s);
    if (v.rst || s == 5'd0) return 32'd0;
    if (v.en && v.rd == s) return mmerge(mregs[s], v.din, v.be);
    return mregs[s];
  endfunction

  function automatic logic mbusy(vec_t v, logic [4:0] s);
    return !v.rst && s != 5'd0 && msb[s] && !(v.en && v.rd == s);
  endfunction

  function automatic logic mready(vec_t v);
    return !v.rst && (!msb[v.ra] || (v.en && v.rd == v.ra) || v.ra == 5'd0);
  endfunction

  function automatic vec_t model_expect(vec_t v);
    vec_t t = v;
    t.op0 = mread(v, v.rs0);
    t.op1 = mread(v, v.rs1);
    t.bsy = {mbusy(v, v.rs1), mbusy(v, v.rs0)};
    t.rdy = mready(v);
    t.cnt = v.rst ? 6'd0 : 6'($countones(msb));
    return t;
  endfunction

  task automatic model_edge(input vec_t v);
    logic rdy;
    if (v.rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      msb = 32'd0;
    end else begin
      rdy = mready(v);
      if (v.en && v.rd != 5'd0) begin
        mregs[v.rd] = mmerge(mregs[v.rd], v.din, v.be);
        msb[v.rd] = 1'b0;
      end
      if (v.rv && rdy && v.ra != 5'd0) msb[v.ra] = 1'b1;
    end
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h want %h", nm, idx, got, want);
    end
  endtask

  // Drive at negedge, queue the expectation, check it before the next posedge
  task automatic apply(input vec_t v, input bit use_model, input int idx);
    vec_t e;
    @(negedge clk);
    rst = v.rst; en = v.en; be = v.be; rd_addr = v.rd; data_in = v.din;
    rs_addr = {v.rs1, v.rs0}; rsv_valid = v.rv; rsv_addr = v.ra;
    if (use_model) v = model_expect(v);
    exp_q.push_back(v);
    #2;
    e = exp_q.pop_front();
    chk("op0", idx, op[31:0], e.op0);
    chk("op1", idx, op[63:32], e.op1);
    chk("busy", idx, 32'(busy), 32'(e.bsy));
    chk("rsv_ready", idx, 32'(rsv_ready), 32'(e.rdy));
    chk("busy_cnt", idx, 32'(busy_cnt), 32'(e.cnt));
    @(posedge clk);
    model_edge(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst = 1'b1; en = 1'b0; be = '0; rd_addr = '0; data_in = '0;
    rs_addr = '0; rsv_valid = 1'b0; rsv_addr = '0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    msb = 32'd0;

    // reset for two clocks; en and reservation presented during reset are ignored
    tbl.push_back(mk(1, 1, 4'hF, 5'd3, 32'h1111_1111, 5'd0, 5'd1, 1, 5'd3, 0, 0, 2'b00, 0, 0));
    tbl.push_back(mk(1, 0, 4'h0, 5'd0, 32'h0, 5'd2, 5'd3, 1, 5'd4, 0, 0, 2'b00, 0, 0));
    for (int r = 0; r < 16; r++)
      tbl.push_back(mk(0, 0, 4'h0, 5'd0, 32'h0, 5'(2*r), 5'(2*r+1), 0, 5'd0, 0, 0, 2'b00, 1, 0));
    // full-word write with same-cycle bypass, then hold
    tbl.push_back(mk(0, 1, 4'hF, 5'd1, 32'h5555_71CA, 5'd1, 5'd1, 0, 5'd0,
                     32'h5555_71CA, 32'h5555_71CA, 2'b00, 1, 0));
    tbl.push_back(mk(0, 0, 4'h0, 5'd0, 32'h0, 5'd1, 5'd0, 0, 5'd0, 32'h5555_71CA, 0, 2'b00, 1, 0));
    // byte-masked partial write
    tbl.push_back(mk(0, 1, 4'hF, 5'd2, 32'h0000_3FFF, 5'd2, 5'd1, 0, 5'd0,
                     32'h0000_3FFF, 32'h5555_71CA, 2'b00, 1, 0));
    tbl.push_back(mk(0, 1, 4'b0100, 5'd2, 32'hAABB_CCDD, 5'd2, 5'd3, 0, 5'd0,
                     32'h00BB_3FFF, 0, 2'b00, 1, 0));
    tbl.push_back(mk(0, 0, 4'h0, 5'd0, 32'h0, 5'd2, 5'd2, 0, 5'd0,
                     32'h00BB_3FFF, 32'h00BB_3FFF, 2'b00, 1, 0));
    // reserve r5, refused re-reserve, then write+reserve r5 same cycle
    tbl.push_back(mk(0, 0, 4'h0, 5'd0, 32'h0, 5'd5, 5'd5, 1, 5'd5, 0, 0, 2'b00, 1, 0));
    tbl.push_back(mk(0, 0, 4'h0, 5'd0, 32'h0, 5'd0, 5'd5, 1, 5'd5, 0, 0, 2'b10, 0, 1));
    tbl.push_back(mk(0, 1, 4'hF, 5'd5, 32'h1234_5678, 5'd5, 5'd2, 1, 5'd5,
                     32'h1234_5678, 32'h00BB_3FFF, 2'b00, 1, 1));
    tbl.push_back(mk(0, 0, 4'h0, 5'd0, 32'h0, 5'd5, 5'd5, 0, 5'd5,
                     32'h1234_5678, 32'h1234_5678, 2'b11, 0, 1));
    // zero register: write and reservation both discarded
    tbl.push_back(mk(0, 1, 4'hF, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd5, 1, 5'd0,
                     0, 32'h1234_5678, 2'b10, 1, 1));
    tbl.push_back(mk(0, 0, 4'h0, 5'd0, 32'h0, 5'd0, 5'd5, 0, 5'd0,
                     0, 32'h1234_5678, 2'b10, 1, 1));
    // be=0 completion clears the busy bit without changing data
    tbl.push_back(mk(0, 1, 4'h0, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 0, 5'd5,
                     32'h1234_5678, 32'h1234_5678, 2'b00, 1, 1));
    tbl.push_back(mk(0, 0, 4'h0, 5'd0, 32'h0, 5'd5, 5'd1, 0, 5'd5,
                     32'h1234_5678, 32'h5555_71CA, 2'b00, 1, 0));
    // reserve r3, r4; clear r3 while setting r6; then reset mid-sequence
    tbl.push_back(mk(0, 0, 4'h0, 5'd0, 32'h0, 5'd3, 5'd4, 1, 5'd3, 0, 0, 2'b00, 1, 0));
    tbl.push_back(mk(0, 0, 4'h0, 5'd0, 32'h0, 5'd3, 5'd4, 1, 5'd4, 0, 0, 2'b01, 1, 1));
    tbl.push_back(mk(0, 1, 4'hF, 5'd3, 32'h0000_00AA, 5'd3, 5'd4, 1, 5'd6,
                     32'h0000_00AA, 0, 2'b10, 1, 2));
    tbl.push_back(mk(0, 0, 4'h0, 5'd0, 32'h0, 5'd6, 5'd3, 0, 5'd6,
                     0, 32'h0000_00AA, 2'b01, 0, 2));
    tbl.push_back(mk(1, 1, 4'hF, 5'd9, 32'hFFFF_FFFF, 5'd4, 5'd6, 1, 5'd7, 0, 0, 2'b00, 0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 5'd0, 32'h0, 5'd3, 5'd7, 0, 5'd7, 0, 0, 2'b00, 1, 0));
    tbl.push_back(mk(0, 0, 4'h0, 5'd0, 32'h0, 5'd1, 5'd9, 0, 5'd4, 0, 0, 2'b00, 1, 0));

    foreach (tbl[i]) apply(tbl[i], 1'b0, i);

    // random traffic over a small address window to force collisions
    for (int i = 0; i < 400; i++) begin
      v = '0;
      v.rst = ($urandom_range(0, 99) == 0);
      v.en  = 1'($urandom_range(0, 1));
      v.be  = 4'($urandom);
      v.rd  = 5'($urandom_range(0, 7));
      v.din = $urandom;
      v.rs0 = 5'($urandom_range(0, 7));
      v.rs1 = 5'($urandom_range(0, 7));
      v.rv  = 1'($urandom_range(0, 1));
      v.ra  = 5'($urandom_range(0, 7));
      apply(v, 1'b1, 1000 + i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
